// File: rtl/lr35902_snd_pulse_if.sv
// Register bus between the sound unit's register decoder and one pulse voice.
interface lr35902_snd_pulse_if;
  logic [2:0] adr;
  logic [7:0] din;
  logic       write;
  logic       read;
  logic [7:0] dout;

  modport master (
    output adr,
    output din,
    output write,
    output read,
    input  dout
  );

  modport slave (
    input  adr,
    input  din,
    input  write,
    input  read,
    output dout
  );
endinterface

// File: rtl/lr35902_snd_pulse.sv
// LR35902 pulse voice (channels 1/2): NRx0..NRx4 registers, duty sequencer, length, envelope.
// Frequency sweep (NRx0) is built only when SND_PULSE_SWEEP_EN is defined.
module lr35902_snd_pulse #(
  parameter int unsigned FREQ_W = 11,
  parameter int unsigned LEN_W  = 6,
  parameter int unsigned VOL_W  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ena,
  lr35902_snd_pulse_if.slave bus,
  input  logic               tick_freq,
  input  logic               tick_len,
  input  logic               tick_env,
  input  logic               tick_swp,
  output logic [VOL_W-1:0]   sample,
  output logic               active
);

  localparam logic [LEN_W:0] LenFull = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0] LenOne  = {{LEN_W{1'b0}}, 1'b1};

  function automatic logic [7:0] duty_pat(input logic [1:0] d);
    logic [7:0] p;
    case (d)
      2'b00:   p = 8'b0000_0001;
      2'b01:   p = 8'b1000_0001;
      2'b10:   p = 8'b1000_0111;
      default: p = 8'b0111_1110;
    endcase
    return p;
  endfunction

  logic [1:0]        duty_q, duty_d;
  logic [LEN_W:0]    len_cnt_q, len_cnt_d;
  logic              cntlen_q, cntlen_d;
  logic [VOL_W-1:0]  init_vol_q, init_vol_d;
  logic              env_dir_q, env_dir_d;
  logic [2:0]        env_period_q, env_period_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [FREQ_W-1:0] timer_q, timer_d;
  logic [2:0]        step_q, step_d;
  logic [VOL_W-1:0]  vol_q, vol_d;
  logic [2:0]        env_cnt_q, env_cnt_d;
  logic              active_q, active_d;
  logic [VOL_W-1:0]  sample_q, sample_d;
  logic [7:0]        dout_q, dout_d;

  logic [7:0] pat;
  logic [7:0] nr0, nr1, nr2, nr4, rd_val;
  logic       dac_on;

`ifdef SND_PULSE_SWEEP_EN
  logic [2:0]        swp_period_q, swp_period_d;
  logic              swp_dec_q, swp_dec_d;
  logic [2:0]        swp_shift_q, swp_shift_d;
  logic [FREQ_W-1:0] shadow_q, shadow_d;
  logic [3:0]        swp_cnt_q, swp_cnt_d;
  logic              swp_on_q, swp_on_d;
  logic [FREQ_W:0]   swp_next, swp_trig_next;
  logic [3:0]        swp_reload;

  // One extra bit so the carry out of an increment is the overflow flag.
  function automatic logic [FREQ_W:0] swp_calc(input logic [FREQ_W-1:0] base,
                                               input logic [2:0] shift, input logic dec);
    logic [FREQ_W:0] b;
    logic [FREQ_W:0] delta;
    b     = {1'b0, base};
    delta = b >> shift;
    return dec ? (b - delta) : (b + delta);
  endfunction
`else
  logic swp_unused;
  assign swp_unused = tick_swp;
`endif

  assign dac_on = (init_vol_q != '0) || env_dir_q;
  assign pat    = duty_pat(duty_q);

  // Read view masks register contents while the voice is held cleared.
  always_comb begin
`ifdef SND_PULSE_SWEEP_EN
    nr0 = {1'b1, {swp_period_q, swp_dec_q, swp_shift_q} & {7{ena}}};
`else
    nr0 = 8'hff;
`endif
    nr1 = {duty_q & {2{ena}}, 6'h3f};
    nr2 = {init_vol_q[3:0], env_dir_q, env_period_q} & {8{ena}};
    nr4 = {1'b1, cntlen_q & ena, 6'h3f};
    case (bus.adr)
      3'd0:    rd_val = nr0;
      3'd1:    rd_val = nr1;
      3'd2:    rd_val = nr2;
      3'd4:    rd_val = nr4;
      default: rd_val = 8'hff;
    endcase
  end

  always_comb begin
    duty_d       = duty_q;
    len_cnt_d    = len_cnt_q;
    cntlen_d     = cntlen_q;
    init_vol_d   = init_vol_q;
    env_dir_d    = env_dir_q;
    env_period_d = env_period_q;
    freq_d       = freq_q;
    timer_d      = timer_q;
    step_d       = step_q;
    vol_d        = vol_q;
    env_cnt_d    = env_cnt_q;
    active_d     = active_q;
    sample_d     = (active_q && pat[step_q]) ? vol_q : '0;
    dout_d       = bus.read ? rd_val : dout_q;
`ifdef SND_PULSE_SWEEP_EN
    swp_period_d  = swp_period_q;
    swp_dec_d     = swp_dec_q;
    swp_shift_d   = swp_shift_q;
    shadow_d      = shadow_q;
    swp_cnt_d     = swp_cnt_q;
    swp_on_d      = swp_on_q;
    swp_reload    = (swp_period_q != 3'd0) ? {1'b0, swp_period_q} : 4'd8;
    swp_next      = swp_calc(shadow_q, swp_shift_q, swp_dec_q);
    swp_trig_next = '0;
`endif

    if (tick_freq) begin
      if (timer_q == '1) begin
        timer_d = freq_q;
        step_d  = step_q + 3'd1;
      end else begin
        timer_d = timer_q + FREQ_W'(1);
      end
    end

    if (tick_len && cntlen_q && (len_cnt_q != '0)) begin
      len_cnt_d = len_cnt_q - LenOne;
      if (len_cnt_q == LenOne) active_d = 1'b0;
    end

    if (tick_env && (env_period_q != 3'd0)) begin
      if (env_cnt_q <= 3'd1) begin
        env_cnt_d = env_period_q;
        if (env_dir_q && (vol_q != '1)) vol_d = vol_q + VOL_W'(1);
        else if (!env_dir_q && (vol_q != '0)) vol_d = vol_q - VOL_W'(1);
      end else begin
        env_cnt_d = env_cnt_q - 3'd1;
      end
    end

`ifdef SND_PULSE_SWEEP_EN
    if (tick_swp) begin
      if (swp_cnt_q <= 4'd1) begin
        swp_cnt_d = swp_reload;
        if (swp_on_q && (swp_period_q != 3'd0)) begin
          if (!swp_dec_q && swp_next[FREQ_W]) begin
            active_d = 1'b0;
          end else if (swp_shift_q != 3'd0) begin
            freq_d   = swp_next[FREQ_W-1:0];
            shadow_d = swp_next[FREQ_W-1:0];
          end
        end
      end else begin
        swp_cnt_d = swp_cnt_q - 4'd1;
      end
    end
`endif

    // Register writes come after the ticks so they win on shared fields.
    if (bus.write) begin
      case (bus.adr)
`ifdef SND_PULSE_SWEEP_EN
        3'd0: begin
          swp_period_d = bus.din[6:4];
          swp_dec_d    = bus.din[3];
          swp_shift_d  = bus.din[2:0];
        end
`endif
        3'd1: begin
          duty_d    = bus.din[7:6];
          len_cnt_d = LenFull - {1'b0, bus.din[LEN_W-1:0]};
        end
        3'd2: begin
          init_vol_d   = VOL_W'(bus.din[7:4]);
          env_dir_d    = bus.din[3];
          env_period_d = bus.din[2:0];
          if (bus.din[7:3] == 5'd0) active_d = 1'b0;
        end
        3'd3: freq_d = {freq_q[FREQ_W-1:8], bus.din};
        3'd4: begin
          freq_d   = {bus.din[FREQ_W-9:0], freq_q[7:0]};
          cntlen_d = bus.din[6];
          if (bus.din[7] && dac_on) begin
            active_d  = 1'b1;
            timer_d   = freq_d;
            step_d    = step_q;
            vol_d     = init_vol_q;
            env_cnt_d = env_period_q;
            len_cnt_d = (len_cnt_q == '0) ? LenFull : len_cnt_q;
`ifdef SND_PULSE_SWEEP_EN
            shadow_d      = freq_d;
            swp_cnt_d     = swp_reload;
            swp_on_d      = (swp_period_q != 3'd0) || (swp_shift_q != 3'd0);
            swp_trig_next = swp_calc(freq_d, swp_shift_q, swp_dec_q);
            if ((swp_shift_q != 3'd0) && !swp_dec_q && swp_trig_next[FREQ_W]) active_d = 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end

    if (!ena) begin
      duty_d       = '0;
      len_cnt_d    = '0;
      cntlen_d     = 1'b0;
      init_vol_d   = '0;
      env_dir_d    = 1'b0;
      env_period_d = '0;
      freq_d       = '0;
      timer_d      = '0;
      step_d       = '0;
      vol_d        = '0;
      env_cnt_d    = '0;
      active_d     = 1'b0;
      sample_d     = '0;
      dout_d       = bus.read ? rd_val : 8'hff;
`ifdef SND_PULSE_SWEEP_EN
      swp_period_d = '0;
      swp_dec_d    = 1'b0;
      swp_shift_d  = '0;
      shadow_d     = '0;
      swp_cnt_d    = '0;
      swp_on_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      duty_q       <= '0;
      len_cnt_q    <= '0;
      cntlen_q     <= 1'b0;
      init_vol_q   <= '0;
      env_dir_q    <= 1'b0;
      env_period_q <= '0;
      freq_q       <= '0;
      timer_q      <= '0;
      step_q       <= '0;
      vol_q        <= '0;
      env_cnt_q    <= '0;
      active_q     <= 1'b0;
      sample_q     <= '0;
      dout_q       <= 8'hff;
`ifdef SND_PULSE_SWEEP_EN
      swp_period_q <= '0;
      swp_dec_q    <= 1'b0;
      swp_shift_q  <= '0;
      shadow_q     <= '0;
      swp_cnt_q    <= '0;
      swp_on_q     <= 1'b0;
`endif
    end else begin
      duty_q       <= duty_d;
      len_cnt_q    <= len_cnt_d;
      cntlen_q     <= cntlen_d;
      init_vol_q   <= init_vol_d;
      env_dir_q    <= env_dir_d;
      env_period_q <= env_period_d;
      freq_q       <= freq_d;
      timer_q      <= timer_d;
      step_q       <= step_d;
      vol_q        <= vol_d;
      env_cnt_q    <= env_cnt_d;
      active_q     <= active_d;
      sample_q     <= sample_d;
      dout_q       <= dout_d;
`ifdef SND_PULSE_SWEEP_EN
      swp_period_q <= swp_period_d;
      swp_dec_q    <= swp_dec_d;
      swp_shift_q  <= swp_shift_d;
      shadow_q     <= shadow_d;
      swp_cnt_q    <= swp_cnt_d;
      swp_on_q     <= swp_on_d;
`endif
    end
  end

  assign bus.dout = dout_q;
  assign sample   = sample_q;
  assign active   = active_q;

endmodule

// File: tb/tb_lr35902_snd_pulse.sv
// Directed self-checking bench for lr35902_snd_pulse; sweep steps need SND_PULSE_SWEEP_EN.
module tb_lr35902_snd_pulse;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ena = 1'b1;
  logic       tick_freq = 1'b0;
  logic       tick_len = 1'b0;
  logic       tick_env = 1'b0;
  logic       tick_swp = 1'b0;
  logic [3:0] sample;
  logic       active;
  logic [7:0] pat10;
  int         checks = 0;
  int         errors = 0;

  lr35902_snd_pulse_if bus ();

  lr35902_snd_pulse dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ena       (ena),
    .bus       (bus),
    .tick_freq (tick_freq),
    .tick_len  (tick_len),
    .tick_env  (tick_env),
    .tick_swp  (tick_swp),
    .sample    (sample),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, want);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.adr   = a;
    bus.din   = d;
    bus.write = 1'b1;
    cyc();
    bus.write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] want);
    bus.adr  = a;
    bus.read = 1'b1;
    cyc();
    bus.read = 1'b0;
    chk(tag, bus.dout, want);
  endtask

  initial begin
    bus.adr   = 3'd0;
    bus.din   = 8'h00;
    bus.write = 1'b0;
    bus.read  = 1'b0;
    pat10     = 8'b1000_0111;
    cyc();
    cyc();
    chk("rst_active", {7'd0, active}, 8'h00);
    chk("rst_sample", {4'd0, sample}, 8'h00);
    chk("rst_dout", bus.dout, 8'hff);
    reset_n = 1'b1;
    cyc();

    // Duty 10 at freq 7FE: step advances every second tick.
    wr(3'd2, 8'hF3);
    wr(3'd1, 8'h80);
    wr(3'd3, 8'hFE);
    wr(3'd4, 8'h87);
    chk("trig_active", {7'd0, active}, 8'h01);
    for (int k = 1; k <= 16; k++) begin
      tick_freq = 1'b1;
      cyc();
      chk($sformatf("duty10_k%0d", k), {4'd0, sample}, pat10[(k - 1) / 2] ? 8'h0f : 8'h00);
    end
    tick_freq = 1'b0;
    rd("rd_nr1", 3'd1, 8'hBF);
    rd("rd_nr2", 3'd2, 8'hF3);
    rd("rd_nr3", 3'd3, 8'hFF);
    rd("rd_nr4", 3'd4, 8'hBF);
    rd("rd_adr5", 3'd5, 8'hFF);
`ifdef SND_PULSE_SWEEP_EN
    rd("rd_nr0", 3'd0, 8'h80);
`else
    rd("rd_nr0", 3'd0, 8'hFF);
`endif

    // Retrigger at volume 9, then reset mid-note.
    wr(3'd2, 8'h90);
    wr(3'd4, 8'h87);
    cyc();
    chk("vol9_sample", {4'd0, sample}, 8'h09);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("midrst_active", {7'd0, active}, 8'h00);
    chk("midrst_sample", {4'd0, sample}, 8'h00);
    chk("midrst_dout", bus.dout, 8'hff);
    rd("midrst_nr2", 3'd2, 8'h00);

    // Length counter of 2 expires on the second tick.
    wr(3'd2, 8'hF0);
    wr(3'd1, 8'h3E);
    wr(3'd4, 8'hC0);
    chk("len_trig_active", {7'd0, active}, 8'h01);
    tick_len = 1'b1;
    cyc();
    chk("len_t1_active", {7'd0, active}, 8'h01);
    chk("len_t1_sample", {4'd0, sample}, 8'h0f);
    cyc();
    chk("len_t2_active", {7'd0, active}, 8'h00);
    tick_len = 1'b0;
    cyc();
    chk("len_off_sample", {4'd0, sample}, 8'h00);
    tick_len = 1'b1;
    repeat (3) cyc();
    // Trigger beats the coincident length tick and reloads a full count.
    wr(3'd4, 8'hC0);
    chk("len_retrig_active", {7'd0, active}, 8'h01);
    repeat (63) cyc();
    chk("len63_active", {7'd0, active}, 8'h01);
    cyc();
    chk("len64_active", {7'd0, active}, 8'h00);
    tick_len = 1'b0;

    // Envelope up from 14 saturates at 15.
    wr(3'd2, 8'hE9);
    wr(3'd1, 8'h00);
    wr(3'd4, 8'h80);
    cyc();
    chk("env_up_0", {4'd0, sample}, 8'h0e);
    tick_env = 1'b1;
    cyc();
    chk("env_up_1", {4'd0, sample}, 8'h0e);
    cyc();
    chk("env_up_2", {4'd0, sample}, 8'h0f);
    cyc();
    chk("env_up_3", {4'd0, sample}, 8'h0f);
    tick_env = 1'b0;
    cyc();
    chk("env_up_4", {4'd0, sample}, 8'h0f);
    wr(3'd2, 8'h00);
    chk("dac_off_active", {7'd0, active}, 8'h00);
    cyc();
    chk("dac_off_sample", {4'd0, sample}, 8'h00);

    // Envelope down from 1 saturates at 0.
    wr(3'd2, 8'h11);
    wr(3'd4, 8'h80);
    cyc();
    chk("env_dn_0", {4'd0, sample}, 8'h01);
    tick_env = 1'b1;
    cyc();
    chk("env_dn_1", {4'd0, sample}, 8'h01);
    cyc();
    chk("env_dn_2", {4'd0, sample}, 8'h00);
    cyc();
    chk("env_dn_3", {4'd0, sample}, 8'h00);
    tick_env = 1'b0;

    // Master enable low clears the voice and blocks writes.
    wr(3'd2, 8'hF0);
    wr(3'd4, 8'h80);
    chk("ena_pre_active", {7'd0, active}, 8'h01);
    ena = 1'b0;
    cyc();
    chk("ena_off_active", {7'd0, active}, 8'h00);
    wr(3'd2, 8'hF0);
    rd("ena_off_nr2", 3'd2, 8'h00);
    rd("ena_off_nr4", 3'd4, 8'hBF);
    ena = 1'b1;
    rd("ena_on_nr2", 3'd2, 8'h00);
    rd("ena_on_nr1", 3'd1, 8'h3F);

`ifdef SND_PULSE_SWEEP_EN
    wr(3'd2, 8'hF0);
    wr(3'd0, 8'h11);
    rd("swp_rd_11", 3'd0, 8'h91);
    wr(3'd3, 8'h00);
    wr(3'd4, 8'h87);
    tick_swp = 1'b1;
    cyc();
    tick_swp = 1'b0;
    chk("swp_ovf_active", {7'd0, active}, 8'h00);
    wr(3'd0, 8'h19);
    rd("swp_rd_19", 3'd0, 8'h99);
    wr(3'd4, 8'h87);
    chk("swp_dec_trig", {7'd0, active}, 8'h01);
    tick_swp = 1'b1;
    cyc();
    tick_swp = 1'b0;
    chk("swp_dec_active", {7'd0, active}, 8'h01);
    // Swept freq 380 keeps low byte 80: one step takes 0x480 ticks.
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h00);
    wr(3'd4, 8'h83);
    for (int i = 0; i < 1151; i++) begin
      tick_freq = 1'b1;
      cyc();
    end
    tick_freq = 1'b0;
    cyc();
    chk("swp_freq_step0", {4'd0, sample}, 8'h0f);
    tick_freq = 1'b1;
    cyc();
    tick_freq = 1'b0;
    cyc();
    chk("swp_freq_step1", {4'd0, sample}, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
